// File: rtl/config_loader.sv
// config_loader: byte-stream configuration loader for one logic tile and its
// 4x4 switch box. Frames start with header 0xA5 and carry seven payload bytes
// P0..P6. Payload is staged in a shadow register and copied to the outputs
// only when the frame commits.
//
// Build option: define CFG_CHECKSUM_EN to add a trailing checksum byte, which
// must equal the XOR of P0..P6. Without it, every complete frame commits and
// cfg_err stays low.
//
// state  | meaning
// IDLE   | hunting for the 0xA5 header; other bytes are dropped
// LOAD   | collecting payload bytes P0..P6 into the shadow register
// CHECK  | waiting for the checksum byte (CFG_CHECKSUM_EN builds only)
// COMMIT | one cycle, not ready; copies shadow to outputs or flags an error

module config_loader (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_data,
  output logic        cfg_ready,
  input  logic        cfg_abort,
  output logic [32:0] tile_mem,
  output logic [15:0] sb_configure,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        cfg_loaded
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef CFG_CHECKSUM_EN
    CHECK  = 2'd2,
`endif
    COMMIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [55:0] shadow_q, shadow_d;
  logic [32:0] tile_q, tile_d;
  logic [15:0] sb_q, sb_d;
  logic        done_q, done_d;
  logic        loaded_q, loaded_d;
  logic        accept;
`ifdef CFG_CHECKSUM_EN
  logic        err_q, err_d;
  logic        match_q, match_d;
  logic [7:0]  csum;
`endif

  // A byte moves only when both sides agree; COMMIT is the only stall state.
  assign cfg_ready = (state_q != COMMIT);
  assign accept    = cfg_valid & cfg_ready;

`ifdef CFG_CHECKSUM_EN
  // Running checksum over every bit of the staged payload, P4[7:1] included.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 7; i++) begin
      csum = csum ^ shadow_q[i*8 +: 8];
    end
  end
`endif

  // Next-state and next-output logic; abort is ignored only in COMMIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tile_d   = tile_q;
    sb_d     = sb_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
`ifdef CFG_CHECKSUM_EN
    err_d    = 1'b0;
    match_d  = match_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (!cfg_abort && accept && (cfg_data == 8'hA5)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (accept) begin
          // A repeated 0xA5 here is ordinary payload, never a resync.
          shadow_d[{cnt_q, 3'b000} +: 8] = cfg_data;
          if (cnt_q == 3'd6) begin
            cnt_d   = 3'd0;
`ifdef CFG_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
`ifdef CFG_CHECKSUM_EN
      CHECK: begin
        if (cfg_abort) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (accept) begin
          match_d = (cfg_data == csum);
          state_d = COMMIT;
        end
      end
`endif
      COMMIT: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
`ifdef CFG_CHECKSUM_EN
        if (match_q) begin
`endif
          tile_d   = {shadow_q[32], shadow_q[31:0]};
          sb_d     = shadow_q[55:40];
          done_d   = 1'b1;
          loaded_d = 1'b1;
`ifdef CFG_CHECKSUM_EN
        end else begin
          err_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // All state and registered outputs; reset clears everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      shadow_q <= 56'd0;
      tile_q   <= 33'd0;
      sb_q     <= 16'd0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      err_q    <= 1'b0;
      match_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tile_q   <= tile_d;
      sb_q     <= sb_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
`ifdef CFG_CHECKSUM_EN
      err_q    <= err_d;
      match_q  <= match_d;
`endif
    end
  end

  assign tile_mem     = tile_q;
  assign sb_configure = sb_q;
  assign cfg_done     = done_q;
  assign cfg_loaded   = loaded_q;
`ifdef CFG_CHECKSUM_EN
  assign cfg_err      = err_q;
`else
  assign cfg_err      = 1'b0;
`endif

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL expose: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL expose: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: cfg_valid  input  1  byte-stream source has a byte on cfg_data.
REQ-004 SHALL expose: cfg_data  input  8  configuration byte.
REQ-005 SHALL expose: cfg_ready  output  1  loader accepts a byte this cycle.
REQ-006 SHALL expose: cfg_abort  input  1  synchronous discard of any frame in progress.
REQ-007 SHALL expose: tile_mem  output  33  logic-tile config; [31:0] LUT contents, [32] flop-bypass select.
REQ-008 SHALL expose: sb_configure  output  16  4x4 switch-box crosspoint config.
REQ-009 SHALL expose: cfg_done  output  1  one-cycle pulse on successful commit.
REQ-010 SHALL expose: cfg_err  output  1  one-cycle pulse on checksum mismatch.
REQ-011 SHALL expose: cfg_loaded  output  1  level; at least one frame committed since reset.

Function
REQ-012 Byte SHALL transfer only on a rising clock edge with cfg_valid=1 and cfg_ready=1.
REQ-013 Frame SHALL be: header 0xA5, payload bytes P0..P6, then checksum byte C.
REQ-014 States SHALL be IDLE, LOAD, CHECK, COMMIT.
REQ-015 IDLE: accepted 0xA5 -> LOAD with byte counter 0; any other accepted byte discarded silently, stay IDLE.
REQ-016 LOAD: each accepted byte written to a 56-bit shadow register at position counter*8, counter increments; byte P6 -> CHECK.
REQ-017 CHECK: accepted byte compared with XOR of P0..P6 (all bits, including unused ones) -> COMMIT.
REQ-018 cfg_ready SHALL be 1 in IDLE, LOAD, CHECK and 0 in COMMIT, which lasts exactly one cycle, then IDLE.
REQ-019 On COMMIT with match: tile_mem[31:0]={P3,P2,P1,P0}, tile_mem[32]=P4[0], P4[7:1] ignored, sb_configure={P6,P5}; cfg_done=1 for that one cycle; cfg_loaded set.
REQ-020 On COMMIT with mismatch: tile_mem, sb_configure, cfg_loaded unchanged; cfg_err=1 for that one cycle.
REQ-021 Outputs SHALL update on the edge leaving COMMIT; latency from edge accepting C to new tile_mem = 1 cycle.
REQ-022 tile_mem and sb_configure SHALL change only at commit; shadow writes are never visible on outputs.
REQ-023 cfg_abort=1 in any state SHALL force IDLE next edge, clear counter, and never commit; abort wins over a simultaneous accepted byte, which is dropped.
REQ-024 cfg_abort during COMMIT SHALL be ignored; commit completes.
REQ-025 A second 0xA5 inside LOAD SHALL be treated as payload data, not a resync.
REQ-026 cfg_valid with cfg_ready=0 SHALL not consume the byte; source holds it.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, counter 0, shadow 0, tile_mem 0, sb_configure 0, cfg_done 0, cfg_err 0, cfg_loaded 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first byte after release is parsed from IDLE.
REQ-029 cfg_ready SHALL be 1 from the first cycle after reset_n deasserts.

Configuration
REQ-030 Macro CFG_CHECKSUM_EN defined: CHECK state and checksum byte present as above.
REQ-031 CFG_CHECKSUM_EN undefined: frame is header + P0..P6; accepting P6 goes straight to COMMIT, always succeeds; cfg_err tied to 0; CHECK state absent.

Verification
REQ-032 Good frame A5 01 02 03 04 01 34 12 23 -> one cycle after C accepted: tile_mem=33'h1_0403_0201, sb_configure=16'h1234, cfg_done pulse, cfg_loaded=1.
REQ-033 Same frame with C=0x24 -> cfg_err pulse, tile_mem and sb_configure remain 0, cfg_loaded=0.
REQ-034 Bytes 00 FF then good frame -> leading bytes ignored, commit as in REQ-032; cfg_ready low for exactly one cycle.
REQ-035 cfg_abort asserted after P3 then good frame of payload FF..FF, C=FF -> only second frame commits: tile_mem=33'h1_FFFF_FFFF, sb_configure=16'hFFFF.
REQ-036 reset_n pulsed low after P5 of a frame following a successful commit -> all outputs 0 immediately; next full frame commits normally.
REQ-037 cfg_valid toggled randomly during good frame -> identical result to REQ-032; no byte lost or duplicated.
